// File: rtl/cnn_axis_pkg.sv
// cnn_axis_pkg: shared class-count/score-width constants, result error bit and output FSM encodings for the CNN AXI-Stream blocks
package cnn_axis_pkg;
  localparam int CNN_NUM_CLASSES = 10;
  localparam int CNN_SCORE_W = 32;
  localparam int CNN_RES_ERR_BIT = 31;
  typedef enum logic [1:0] {ST_ACC, ST_OUT, ST_OUT_SCORE} state_t;
endpackage

// File: rtl/signed_max_cmp.sv
// signed_max_cmp: one running signed max/argmax step (score, max_in, idx_in, cnt -> max_out, idx_out); cnt==0 seeds, later beats win only when strictly greater
module signed_max_cmp
  import cnn_axis_pkg::*;
#(
  parameter int DATA_W = CNN_SCORE_W,
  parameter int IDX_W = 4
) (
  input  logic [DATA_W-1:0] score,
  input  logic [DATA_W-1:0] max_in,
  input  logic [IDX_W-1:0]  idx_in,
  input  logic [IDX_W-1:0]  cnt,
  output logic [DATA_W-1:0] max_out,
  output logic [IDX_W-1:0]  idx_out
);
  logic take;
  assign take = cnt == '0 || $signed(score) > $signed(max_in);
  assign max_out = take ? score : max_in;
  assign idx_out = take ? cnt : idx_in;
endmodule

// File: rtl/axis_argmax_classifier.sv
// axis_argmax_classifier: s00 score frames (tdata/tvalid/tlast, tstrb ignored) -> one m00 beat {err@MSB, argmax idx}; ARGMAX_SCORE_OUT_EN adds a second beat with the max score
module axis_argmax_classifier
  import cnn_axis_pkg::*;
#(
  parameter int NUM_CLASSES = CNN_NUM_CLASSES,
  parameter int DATA_W = CNN_SCORE_W,
  parameter int IDX_W = 4
) (
  input  logic                s00_axis_aclk,
  input  logic                s00_axis_aresetn,
  input  logic                s00_axis_tvalid,
  output logic                s00_axis_tready,
  input  logic [DATA_W-1:0]   s00_axis_tdata,
  input  logic [DATA_W/8-1:0] s00_axis_tstrb,
  input  logic                s00_axis_tlast,
  output logic                m00_axis_tvalid,
  input  logic                m00_axis_tready,
  output logic [DATA_W-1:0]   m00_axis_tdata,
  output logic [DATA_W/8-1:0] m00_axis_tstrb,
  output logic                m00_axis_tlast
);
  localparam int ERR_BIT = DATA_W == CNN_SCORE_W ? CNN_RES_ERR_BIT : DATA_W - 1;
  localparam logic [IDX_W:0] NC = (IDX_W+1)'(NUM_CLASSES);
  localparam logic [IDX_W:0] NC_LAST = (IDX_W+1)'(NUM_CLASSES - 1);
`ifdef ARGMAX_SCORE_OUT_EN
  localparam state_t AFTER_IDX = ST_OUT_SCORE;
  localparam logic LAST_ON_IDX = 1'b0;
`else
  localparam state_t AFTER_IDX = ST_ACC;
  localparam logic LAST_ON_IDX = 1'b1;
`endif
  state_t state, nxt;
  logic rdy, hs, in_range, err, nerr;
  logic [IDX_W:0] cnt;
  logic [IDX_W-1:0] idx, cmp_idx, nidx;
  logic [DATA_W-1:0] best, cmp_max, nbest, res, res_nxt;
  logic unused_ok;
  assign unused_ok = ^s00_axis_tstrb;
  signed_max_cmp #(.DATA_W(DATA_W), .IDX_W(IDX_W)) u_cmp (
    .score(s00_axis_tdata),
    .max_in(best),
    .idx_in(idx),
    .cnt(cnt[IDX_W-1:0]),
    .max_out(cmp_max),
    .idx_out(cmp_idx)
  );
  always_comb begin
    hs = s00_axis_tvalid & rdy;
    in_range = cnt < NC;
    nbest = in_range ? cmp_max : best;
    nidx = in_range ? cmp_idx : idx;
    nerr = err | ~in_range | (s00_axis_tlast & (cnt != NC_LAST));
    res_nxt = '0;
    res_nxt[IDX_W-1:0] = nidx;
    res_nxt[ERR_BIT] = nerr;
    case (state)
      ST_ACC:  nxt = hs && s00_axis_tlast ? ST_OUT : ST_ACC;
      ST_OUT:  nxt = m00_axis_tready ? AFTER_IDX : ST_OUT;
      default: nxt = m00_axis_tready || state != ST_OUT_SCORE ? ST_ACC : state;
    endcase
  end
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn)
    if (!s00_axis_aresetn) begin
      state <= ST_ACC;
      rdy <= 1'b0;
      cnt <= '0;
      best <= '0;
      idx <= '0;
      err <= 1'b0;
      res <= '0;
    end else begin
      state <= nxt;
      rdy <= nxt == ST_ACC;
      if (hs) begin
        idx <= nidx;
        res <= res_nxt;
        cnt <= s00_axis_tlast ? '0 : cnt + {{IDX_W{1'b0}}, in_range};
        best <= s00_axis_tlast ? '0 : nbest;
        err <= ~s00_axis_tlast & nerr;
      end
    end
  assign s00_axis_tready = rdy;
  assign m00_axis_tvalid = state != ST_ACC;
  assign m00_axis_tstrb = {(DATA_W/8){m00_axis_tvalid}};
  assign m00_axis_tlast = state == ST_OUT ? LAST_ON_IDX : state == ST_OUT_SCORE;
`ifdef ARGMAX_SCORE_OUT_EN
  logic [DATA_W-1:0] res_score;
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn)
    if (!s00_axis_aresetn) res_score <= '0;
    else if (hs) res_score <= nbest;
  assign m00_axis_tdata = state == ST_OUT ? res : state == ST_OUT_SCORE ? res_score : '0;
`else
  assign m00_axis_tdata = state == ST_OUT ? res : '0;
`endif
endmodule

// File: tb/tb_axis_argmax_classifier.sv
// tb_axis_argmax_classifier: directed score frames checked against a frame-level argmax model plus literal result pins
module tb_axis_argmax_classifier;
  localparam int NC = 10, DW = 32, IW = 4;
`ifdef ARGMAX_SCORE_OUT_EN
  localparam int BPR = 2;
`else
  localparam int BPR = 1;
`endif
  typedef struct {logic [DW-1:0] d; logic l;} beat_t;
  logic clk = 0, rst_n = 0;
  logic s_tvalid = 0, s_tlast = 0, s_tready;
  logic [DW-1:0] s_tdata = '0;
  logic m_tvalid, m_tready = 1, m_tlast;
  logic [DW-1:0] m_tdata;
  logic [DW/8-1:0] m_tstrb;
  int total = 0, bad = 0, stall_cycles = 0;
  int fq[$];
  logic [DW-1:0] cur[$];
  logic [DW-1:0] got[$];
  beat_t expq[$];
  logic lat_pend = 0, was_stall = 0;
  logic [DW-1:0] held = '0;
  always #5 clk = ~clk;
  axis_argmax_classifier #(.NUM_CLASSES(NC), .DATA_W(DW), .IDX_W(IW)) dut (
    .s00_axis_aclk(clk),
    .s00_axis_aresetn(rst_n),
    .s00_axis_tvalid(s_tvalid),
    .s00_axis_tready(s_tready),
    .s00_axis_tdata(s_tdata),
    .s00_axis_tstrb(4'hF),
    .s00_axis_tlast(s_tlast),
    .m00_axis_tvalid(m_tvalid),
    .m00_axis_tready(m_tready),
    .m00_axis_tdata(m_tdata),
    .m00_axis_tstrb(m_tstrb),
    .m00_axis_tlast(m_tlast)
  );
  task automatic chk(input string nm, input logic [DW-1:0] a, input logic [DW-1:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", nm, a, e);
    end
  endtask
  function automatic void model();
    int n = cur.size();
    int bi = 0;
    logic signed [DW-1:0] bv = cur[0];
    logic [DW-1:0] w = '0;
    for (int i = 1; i < n && i < NC; i++)
      if ($signed(cur[i]) > bv) begin
        bv = cur[i];
        bi = i;
      end
    w[IW-1:0] = bi[IW-1:0];
    w[DW-1] = n != NC;
    expq.push_back(beat_t'{d: w, l: BPR == 1});
    if (BPR == 2) expq.push_back(beat_t'{d: bv, l: 1'b1});
  endfunction
  always @(negedge clk) begin
    beat_t b;
    if (!rst_n) begin
      chk("rst_s_tready", s_tready, 0);
      chk("rst_m_tvalid", m_tvalid, 0);
      chk("rst_m_tdata", m_tdata, 0);
      chk("rst_m_tstrb", m_tstrb, 0);
      chk("rst_m_tlast", m_tlast, 0);
      cur.delete();
      expq.delete();
      lat_pend = 0;
      was_stall = 0;
    end else begin
      chk("tstrb", m_tstrb, {4{m_tvalid}});
      if (lat_pend) chk("latency_tvalid", m_tvalid, 1);
      lat_pend = 0;
      if (m_tvalid) chk("s_tready_during_out", s_tready, 0);
      if (was_stall) begin
        chk("stall_tvalid", m_tvalid, 1);
        chk("stall_tdata", m_tdata, held);
      end
      was_stall = m_tvalid && !m_tready;
      held = m_tdata;
      if (was_stall) stall_cycles++;
      if (m_tvalid && m_tready) begin
        if (expq.size() == 0) chk("spurious_result", m_tvalid, 0);
        else begin
          b = expq.pop_front();
          chk("tdata", m_tdata, b.d);
          chk("tlast", m_tlast, b.l);
          got.push_back(m_tdata);
        end
      end
      if (s_tvalid && s_tready) begin
        cur.push_back(s_tdata);
        if (s_tlast) begin
          model();
          cur.delete();
          lat_pend = 1;
        end
      end
    end
  end
  task automatic beat(input logic [DW-1:0] d, input logic l);
    logic hs = 0;
    int t = 0;
    s_tvalid = 1;
    s_tdata = d;
    s_tlast = l;
    while (!hs && t < 200) begin
      @(negedge clk);
      hs = s_tready;
      @(posedge clk);
      #1;
      t++;
    end
    if (!hs) begin
      total++;
      bad++;
      $display("FAIL beat_timeout: got=no handshake want=handshake");
    end
    s_tvalid = 0;
    s_tlast = 0;
  endtask
  task automatic send_q(input bit use_last, input bit gap);
    for (int i = 0; i < fq.size(); i++) begin
      beat(fq[i], use_last && i == fq.size() - 1);
      if (gap) begin
        repeat (2) @(posedge clk);
        #1;
      end
    end
  endtask
  task automatic run(input string nm, input logic [DW-1:0] e, input bit gap);
    int b0 = got.size();
    int t = 0;
    send_q(1, gap);
    while (got.size() < b0 + BPR && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk({nm, "_beats"}, got.size() - b0, BPR);
    if (got.size() > b0) chk(nm, got[b0], e);
  endtask
  initial begin
    int b0, s0, t;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    chk("tready_before_edge", s_tready, 0);
    @(posedge clk);
    #1 chk("tready_after_edge", s_tready, 1);
    fq = '{5, -3, 100, 7, 0, 0, 0, 0, 0, 99};
    run("basic", 32'h0000_0002, 0);
`ifdef ARGMAX_SCORE_OUT_EN
    if (got.size() >= 2) chk("basic_score", got[got.size()-1], 32'h0000_0064);
`endif
    fq = '{-1, -1, -1, -1, -1, -1, -1, -1, -1, -1};
    run("tie", 32'h0000_0000, 0);
    fq = {};
    for (int i = 0; i < 10; i++) fq.push_back(i == 7 ? -2147483647 : -2147483647 - 1);
    run("min_vals_gaps", 32'h0000_0007, 1);
    fq = '{1, 9, 3, 2};
    run("short", 32'h8000_0001, 0);
    fq = {};
    for (int i = 0; i < 12; i++) fq.push_back(i == 10 ? 1000 : 0);
    run("long", 32'h8000_0000, 0);
    m_tready = 0;
    b0 = got.size();
    s0 = stall_cycles;
    fq = '{3, 1, 4, 1, 5, 9, 2, 6, 5, 3};
    send_q(1, 0);
    fork
      begin
        repeat (22) @(posedge clk);
        #1 m_tready = 1;
      end
    join_none
    fq = '{0, 0, 0, 0, 0, 0, 0, 0, 50, -7};
    send_q(1, 0);
    t = 0;
    while (got.size() < b0 + 2 * BPR && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("bp_beats", got.size() - b0, 2 * BPR);
    if (got.size() >= b0 + 2 * BPR) begin
      chk("bp_first", got[b0], 32'h0000_0005);
      chk("bp_second", got[b0+BPR], 32'h0000_0008);
    end
    chk("bp_stall_20", stall_cycles - s0 >= 20, 1);
    fq = '{10, 20, 30, 40, 50};
    send_q(0, 0);
    rst_n = 0;
    #1 chk("async_rst_tready", s_tready, 0);
    @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk);
    #1;
    fq = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 77};
    run("after_reset", 32'h0000_0009, 0);
    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
